// File: rtl/branch_redirect_ctrl.sv
// Front-end recovery sequencer: detects branch mispredicts in EX, issues a redirect
// PC to fetch over a valid/ready handshake, then flushes IF/ID and stalls EX.
module branch_redirect_ctrl #(
   parameter int              XLEN         = 32,
   parameter int              FLUSH_CYCLES = 2,
   parameter logic [XLEN-1:0] RESET_PC     = {XLEN{1'b0}}
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            ex_valid_in,
   input  logic [4:0]      ex_opcode_6_to_2_in,
   input  logic [XLEN-1:0] ex_pc_in,
   input  logic [XLEN-1:0] ex_target_in,
   input  logic            ex_branch_taken_in,
   input  logic            ex_pred_taken_in,
   input  logic            redirect_ready_in,
   output logic            redirect_valid_out,
   output logic [XLEN-1:0] redirect_pc_out,
   output logic            flush_out,
   output logic            stall_out,
   output logic [15:0]     branch_count_out,
   output logic [15:0]     mispredict_count_out
);

   localparam int              CW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]   CNT_LOAD  = CW'(FLUSH_CYCLES - 1);
   localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
   localparam logic [XLEN-1:0] TGT_MASK  = ~(XLEN'(1));
   localparam logic [15:0]     CNT_MAX   = 16'hFFFF;
   localparam logic [4:0]      OP_JAL    = 5'b11011;
   localparam logic [4:0]      OP_JALR   = 5'b11001;
   localparam logic [4:0]      OP_BRANCH = 5'b11000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic            redirect_valid_q, redirect_valid_d;
   logic            flush_q, flush_d;
   logic            stall_q, stall_d;
   logic [15:0]     branch_count_q, branch_count_d;
   logic [15:0]     mispredict_count_q, mispredict_count_d;

   logic            is_ctrl_s;
   logic            actual_s;
   logic            mispredict_s;
   logic [XLEN-1:0] target_s;

   // Resolution decode; JALR always redirects because fetch cannot predict its target.
   always_comb begin
      is_ctrl_s    = (ex_opcode_6_to_2_in == OP_JAL) ||
                     (ex_opcode_6_to_2_in == OP_JALR) ||
                     (ex_opcode_6_to_2_in == OP_BRANCH);
      actual_s     = is_ctrl_s & ex_branch_taken_in;
      mispredict_s = ex_valid_in &
                     ((actual_s != ex_pred_taken_in) || (ex_opcode_6_to_2_in == OP_JALR));
      if (actual_s) begin
         target_s = ex_target_in & TGT_MASK;
      end else begin
         target_s = ex_pc_in + PC_STEP;
      end
   end

   // State register and all registered outputs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q            <= ST_IDLE;
         cnt_q              <= {CW{1'b0}};
         redirect_pc_q      <= RESET_PC;
         redirect_valid_q   <= 1'b0;
         flush_q            <= 1'b0;
         stall_q            <= 1'b0;
         branch_count_q     <= 16'h0000;
         mispredict_count_q <= 16'h0000;
      end else begin
         state_q            <= state_d;
         cnt_q              <= cnt_d;
         redirect_pc_q      <= redirect_pc_d;
         redirect_valid_q   <= redirect_valid_d;
         flush_q            <= flush_d;
         stall_q            <= stall_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   // Next state; ex_* are only looked at in IDLE since EX is frozen elsewhere.
   always_comb begin
      state_d            = state_q;
      cnt_d              = cnt_q;
      redirect_pc_d      = redirect_pc_q;
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      case (state_q)
         ST_IDLE: begin
            if (ex_valid_in && is_ctrl_s && (branch_count_q != CNT_MAX)) begin
               branch_count_d = branch_count_q + 16'd1;
            end else begin
               branch_count_d = branch_count_q;
            end
            if (mispredict_s && (mispredict_count_q != CNT_MAX)) begin
               mispredict_count_d = mispredict_count_q + 16'd1;
            end else begin
               mispredict_count_d = mispredict_count_q;
            end
            if (mispredict_s) begin
               state_d       = ST_REQ;
               redirect_pc_d = target_s;
            end else begin
               state_d       = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (redirect_ready_in && (FLUSH_CYCLES > 1)) begin
               state_d = ST_DRAIN;
               cnt_d   = CNT_LOAD;
            end else if (redirect_ready_in) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_DRAIN: begin
            if (cnt_q == CNT_ONE) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d   = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they leave the flops aligned with it.
   always_comb begin
      redirect_valid_d = 1'b0;
      flush_d          = 1'b0;
      stall_d          = 1'b0;
      case (state_d)
         ST_REQ: begin
            redirect_valid_d = 1'b1;
            flush_d          = 1'b1;
            stall_d          = 1'b1;
         end
         ST_DRAIN: begin
            flush_d          = 1'b1;
            stall_d          = 1'b1;
         end
         default: begin
            redirect_valid_d = 1'b0;
         end
      endcase
   end

   assign redirect_valid_out   = redirect_valid_q;
   assign redirect_pc_out      = redirect_pc_q;
   assign flush_out            = flush_q;
   assign stall_out            = stall_q;
   assign branch_count_out     = branch_count_q;
   assign mispredict_count_out = mispredict_count_q;

endmodule
